pipe_hazard_unit: RTL and testbench

Parametrised hazard/forwarding controller for the 5-stage pipelined CPU: fills the empty data-hazard slot and adds branch-flush control. It keeps its own shadow scoreboard of in-flight destination registers (EX, MEM, WB slots). From that scoreboard it produces:
- a load-use stall;
- a branch flush, with the branch resolved in MEM;
- registered operand-forwarding selects for the EX stage.

---
 rtl/pipe_hazard_if.sv | 35 +++
 rtl/pipe_hazard_unit.sv | 110 +++++++++++
 tb/tb_pipe_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard unit bus: ID-stage instruction info and branch resolution in,
// stall/flush/forward controls and perf counters out.
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic              id_wr_en_i;
  logic [REG_AW-1:0] id_wr_addr_i;
  logic              id_mem_read_i;
  logic              branch_taken_i;
  logic              stall_o;
  logic              bubble_o;
  logic              flush_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_wr_en_i, id_wr_addr_i, id_mem_read_i, branch_taken_i,
    input  stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_wr_en_i, id_wr_addr_i, id_mem_read_i, branch_taken_i,
    output stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline. Tracks in-flight
// destination registers in EX/MEM/WB shadow slots and derives load-use
// stall, branch flush and registered EX operand-forward selects.
module pipe_hazard_unit #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter bit RF_WT  = 1'b0,
  parameter int CNT_W  = 16
) (
  input logic          clk_i,
  input logic          rst_n,
  pipe_hazard_if.slave hz
);
  typedef logic [REG_AW-1:0] addr_t;
  // Load flag only matters in EX, so it lives beside the EX slot.
  typedef struct packed {
    logic  vld;
    logic  wr;
    addr_t addr;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t            ex_q, mem_q, wb_q, ex_d, mem_d;
  logic             ex_ld_q, ex_ld_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             need_a, need_b, haz_raw, stall, flush;

  // r0 is hardwired zero: never a producer worth tracking.
  function automatic logic hit(slot_t s, addr_t a);
    return s.vld && s.wr && (s.addr == a) && (a != '0);
  endfunction

  // Youngest writer wins: EX before MEM before WB.
  function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, slot_t wb, addr_t a);
    if (hit(ex, a))            return 2'd2;
    if (hit(mem, a))           return 2'd1;
    if (!RF_WT && hit(wb, a))  return 2'd3;
    return 2'd0;
  endfunction

  // With forwarding only a load still in EX cannot be bypassed; without it
  // every visible producer blocks (WB too unless the RF writes through).
  function automatic logic raw(slot_t ex, logic ex_ld, slot_t mem, slot_t wb, addr_t a);
    if (FWD_EN) return ex_ld && hit(ex, a);
    return hit(ex, a) || hit(mem, a) || (!RF_WT && hit(wb, a));
  endfunction

  // Combinational hazard detection; flush overrides stall.
  always_comb begin
    need_a  = hz.id_valid_i & hz.id_use_rs_i;
    need_b  = hz.id_valid_i & hz.id_use_rt_i;
    haz_raw = (need_a && raw(ex_q, ex_ld_q, mem_q, wb_q, hz.id_rs_i)) ||
              (need_b && raw(ex_q, ex_ld_q, mem_q, wb_q, hz.id_rt_i));
    flush   = hz.branch_taken_i;
    stall   = haz_raw & ~flush;
  end

  // Next slot contents, forward selects and saturating counters.
  always_comb begin
    ex_d.vld  = hz.id_valid_i & ~stall & ~flush;
    ex_d.wr   = hz.id_wr_en_i;
    ex_d.addr = hz.id_wr_addr_i;
    ex_ld_d   = hz.id_mem_read_i;
    mem_d     = ex_q;
    if (flush) mem_d.vld = 1'b0;
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (FWD_EN && !stall && !flush) begin
      if (need_a) fwd_a_d = fwd_sel(ex_q, mem_q, wb_q, hz.id_rs_i);
      if (need_b) fwd_b_d = fwd_sel(ex_q, mem_q, wb_q, hz.id_rt_i);
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers; reset clears every slot so in-flight stalls drop at once.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_ld_q     <= 1'b0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= mem_q;
      ex_ld_q     <= ex_ld_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_o     = stall;
  assign hz.bubble_o    = stall;
  assign hz.flush_o     = flush;
  assign hz.fwd_a_o     = fwd_a_q;
  assign hz.fwd_b_o     = fwd_b_q;
  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three configurations share one stimulus
// stream; each is tracked by an instruction-age reference model.
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: forwarding, WB hold reg; dut1: interlock only, 2-bit counters;
  // dut2: forwarding, write-through RF, 2-bit counters.
  localparam int NK = 3;
  int P_FWD[NK]  = '{1, 0, 1};
  int P_RFWT[NK] = '{0, 0, 1};
  int P_CW[NK]   = '{16, 2, 2};

  logic       t_v, t_urs, t_urt, t_wr, t_ld, t_br;
  logic [4:0] t_rs, t_rt, t_wa;

  pipe_hazard_if #(.REG_AW(5), .CNT_W(16)) if0 ();
  pipe_hazard_if #(.REG_AW(5), .CNT_W(2))  if1 ();
  pipe_hazard_if #(.REG_AW(5), .CNT_W(2))  if2 ();

  assign if0.id_valid_i = t_v, if0.id_rs_i = t_rs, if0.id_rt_i = t_rt, if0.id_use_rs_i = t_urs,
         if0.id_use_rt_i = t_urt, if0.id_wr_en_i = t_wr, if0.id_wr_addr_i = t_wa,
         if0.id_mem_read_i = t_ld, if0.branch_taken_i = t_br;
  assign if1.id_valid_i = t_v, if1.id_rs_i = t_rs, if1.id_rt_i = t_rt, if1.id_use_rs_i = t_urs,
         if1.id_use_rt_i = t_urt, if1.id_wr_en_i = t_wr, if1.id_wr_addr_i = t_wa,
         if1.id_mem_read_i = t_ld, if1.branch_taken_i = t_br;
  assign if2.id_valid_i = t_v, if2.id_rs_i = t_rs, if2.id_rt_i = t_rt, if2.id_use_rs_i = t_urs,
         if2.id_use_rt_i = t_urt, if2.id_wr_en_i = t_wr, if2.id_wr_addr_i = t_wa,
         if2.id_mem_read_i = t_ld, if2.branch_taken_i = t_br;

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .RF_WT(1'b0), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_n(rst_n), .hz(if0.slave));
  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .RF_WT(1'b0), .CNT_W(2)) u1 (
    .clk_i(clk), .rst_n(rst_n), .hz(if1.slave));
  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .RF_WT(1'b1), .CNT_W(2)) u2 (
    .clk_i(clk), .rst_n(rst_n), .hz(if2.slave));

  logic [NK-1:0] st_w, bb_w, fl_w;
  logic [1:0]    fa_w[NK], fb_w[NK];
  logic [15:0]   sc_w[NK], fc_w[NK];
  assign st_w = {if2.stall_o, if1.stall_o, if0.stall_o};
  assign bb_w = {if2.bubble_o, if1.bubble_o, if0.bubble_o};
  assign fl_w = {if2.flush_o, if1.flush_o, if0.flush_o};
  assign fa_w[0] = if0.fwd_a_o, fa_w[1] = if1.fwd_a_o, fa_w[2] = if2.fwd_a_o;
  assign fb_w[0] = if0.fwd_b_o, fb_w[1] = if1.fwd_b_o, fb_w[2] = if2.fwd_b_o;
  assign sc_w[0] = if0.stall_cnt_o, sc_w[1] = 16'(if1.stall_cnt_o), sc_w[2] = 16'(if2.stall_cnt_o);
  assign fc_w[0] = if0.flush_cnt_o, fc_w[1] = 16'(if1.flush_cnt_o), fc_w[2] = 16'(if2.flush_cnt_o);

  int total = 0;
  int bad = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[k][age-1]: instruction that left ID age cycles ago (age 1 = in EX).
  typedef struct { bit v; bit w; bit ld; int a; } ent_t;
  ent_t hist[NK][3];
  int   n_stall[NK], n_flush[NK], e_fa[NK], e_fb[NK];
  logic snap_st[NK], snap_fl[NK];

  function automatic int writer_age(int k, int a);
    if (a == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (hist[k][i].v && hist[k][i].w && hist[k][i].a == a) return i + 1;
    return 0;
  endfunction

  function automatic int fwd_code(int k, int age);
    case (age)
      1: return 2;
      2: return 1;
      3: return P_RFWT[k] ? 0 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit blocks(int k, int a);
    int age = writer_age(k, a);
    if (P_FWD[k]) return age == 1 && hist[k][0].ld;
    return age != 0 && !(age == 3 && P_RFWT[k]);
  endfunction

  function automatic int sat(int k, int n);
    int mx = (1 << P_CW[k]) - 1;
    return n > mx ? mx : n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 3; i++) hist[k][i] = '{0, 0, 0, 0};
      n_stall[k] = 0; n_flush[k] = 0; e_fa[k] = 0; e_fb[k] = 0;
    end
  endtask

  task automatic drive(bit v, int rs, int rt, bit urs, bit urt, bit wr, int wa, bit ld, bit br);
    t_v = v; t_rs = 5'(rs); t_rt = 5'(rt); t_urs = urs; t_urt = urt;
    t_wr = wr; t_wa = 5'(wa); t_ld = ld; t_br = br;
  endtask

  // One cycle: entered at posedge+1, leaves at the next posedge+1.
  task automatic step(bit v, int rs, int rt, bit urs, bit urt, bit wr, int wa, bit ld, bit br);
    bit ms[NK];
    int nfa[NK], nfb[NK];
    drive(v, rs, rt, urs, urt, wr, wa, ld, br);
    #4;
    for (int k = 0; k < NK; k++) begin
      ms[k] = ((v && urs && blocks(k, rs)) || (v && urt && blocks(k, rt))) && !br;
      nfa[k] = (P_FWD[k] && v && urs && !ms[k] && !br) ? fwd_code(k, writer_age(k, rs)) : 0;
      nfb[k] = (P_FWD[k] && v && urt && !ms[k] && !br) ? fwd_code(k, writer_age(k, rt)) : 0;
      snap_st[k] = st_w[k];
      snap_fl[k] = fl_w[k];
      chk($sformatf("stall dut%0d", k), int'(st_w[k]), int'(ms[k]));
      chk($sformatf("bubble dut%0d", k), int'(bb_w[k]), int'(ms[k]));
      chk($sformatf("flush dut%0d", k), int'(fl_w[k]), int'(br));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      hist[k][2] = hist[k][1];
      hist[k][1] = hist[k][0];
      if (br) hist[k][1].v = 0;
      hist[k][0] = '{v && !ms[k] && !br, wr, ld, wa};
      if (ms[k]) n_stall[k]++;
      if (br) n_flush[k]++;
      e_fa[k] = nfa[k];
      e_fb[k] = nfb[k];
      chk($sformatf("fwd_a dut%0d", k), int'(fa_w[k]), e_fa[k]);
      chk($sformatf("fwd_b dut%0d", k), int'(fb_w[k]), e_fb[k]);
      chk($sformatf("stall_cnt dut%0d", k), int'(sc_w[k]), sat(k, n_stall[k]));
      chk($sformatf("flush_cnt dut%0d", k), int'(fc_w[k]), sat(k, n_flush[k]));
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table (dut0 expectations) ----------------
  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; bit wr; int wa; bit ld; bit br;
    bit e_st; bit e_fl; int e_fa; int e_fb;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(bit v, int rs, int rt, bit urs, bit urt, bit wr, int wa, bit ld,
                              bit br, bit es, bit ef, int fa, int fb);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.wr = wr; r.wa = wa;
    r.ld = ld; r.br = br; r.e_st = es; r.e_fl = ef; r.e_fa = fa; r.e_fb = fb;
    return r;
  endfunction

  initial begin
    int n;
    tbl[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);    // add r3,r1,r2
    tbl[1]  = mk(1, 3, 4, 1, 1, 1, 5, 0, 0, 0, 0, 2, 0);    // sub r5,r3,r4 : EX fwd
    tbl[2]  = mk(1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0);    // lw r2,(r1)
    tbl[3]  = mk(1, 2, 2, 1, 1, 1, 6, 0, 0, 1, 0, 0, 0);    // add r6,r2,r2 : load-use stall
    tbl[4]  = mk(1, 2, 2, 1, 1, 1, 6, 0, 0, 0, 0, 1, 1);    // retry : fwd from MEM/WB
    tbl[5]  = mk(1, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0);    // add r7
    tbl[6]  = mk(1, 10, 11, 1, 1, 1, 9, 0, 0, 0, 0, 0, 0);  // independent
    tbl[7]  = mk(1, 10, 11, 1, 1, 1, 12, 0, 0, 0, 0, 0, 0); // independent
    tbl[8]  = mk(1, 7, 0, 1, 1, 1, 8, 0, 0, 0, 0, 3, 0);    // or r8,r7,r0 : WB hold, r0 not fwd
    tbl[9]  = mk(1, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0);    // lw r4
    tbl[10] = mk(1, 4, 4, 1, 1, 1, 13, 0, 1, 0, 1, 0, 0);   // use r4 + branch : flush wins
    tbl[11] = mk(1, 4, 13, 1, 1, 1, 14, 0, 0, 0, 0, 0, 0);  // killed writers invisible
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    // idle
    tbl[13] = mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);    // lw r0
    tbl[14] = mk(1, 0, 0, 1, 1, 1, 15, 0, 0, 0, 0, 0, 0);   // use r0 : no hazard

    // reset state, with a load-use shaped input present
    drive(1, 2, 2, 1, 1, 1, 6, 1, 0);
    model_reset();
    #3;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("rst stall dut%0d", k), int'(st_w[k]), 0);
      chk($sformatf("rst fwd_a dut%0d", k), int'(fa_w[k]), 0);
      chk($sformatf("rst fwd_b dut%0d", k), int'(fb_w[k]), 0);
      chk($sformatf("rst stall_cnt dut%0d", k), int'(sc_w[k]), 0);
      chk($sformatf("rst flush_cnt dut%0d", k), int'(fc_w[k]), 0);
    end
    @(posedge clk); #1;
    do_reset();

    // directed table (plan items 1-4 and r0 boundary)
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wr, tbl[i].wa,
           tbl[i].ld, tbl[i].br);
      chk($sformatf("tbl%0d stall", i), int'(snap_st[0]), int'(tbl[i].e_st));
      chk($sformatf("tbl%0d flush", i), int'(snap_fl[0]), int'(tbl[i].e_fl));
      chk($sformatf("tbl%0d fwd_a", i), int'(fa_w[0]), tbl[i].e_fa);
      chk($sformatf("tbl%0d fwd_b", i), int'(fb_w[0]), tbl[i].e_fb);
    end
    chk("tbl stall_cnt", int'(sc_w[0]), 1);
    chk("tbl flush_cnt", int'(fc_w[0]), 1);

    // interlock mode: ALU producer blocks consumer for 3 cycles
    do_reset();
    step(1, 1, 2, 1, 1, 1, 3, 0, 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 3, 4, 1, 1, 1, 5, 0, 0);
      if (!snap_st[1]) break;
      n++;
      chk("interlock fwd_a", int'(fa_w[1]), 0);
    end
    chk("interlock stalls", n, 3);
    chk("interlock stall_cnt", int'(sc_w[1]), 3);
    // second round pushes the 2-bit counter past saturation
    step(1, 1, 2, 1, 1, 1, 3, 0, 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 3, 4, 1, 1, 1, 5, 0, 0);
      if (!snap_st[1]) break;
      n++;
    end
    chk("interlock stalls 2", n, 3);
    chk("saturated stall_cnt", int'(sc_w[1]), 3);

    // reset asserted in the middle of a load-use stall
    do_reset();
    step(1, 2, 3, 1, 1, 1, 1, 0, 0);   // add r1
    step(1, 1, 0, 1, 0, 1, 2, 1, 0);   // lw r2,(r1) : fwd_a=2
    chk("pre-rst fwd_a", int'(fa_w[0]), 2);
    drive(1, 2, 2, 1, 1, 1, 6, 0, 0);  // add r6,r2,r2
    #2;
    chk("pre-rst stall", int'(st_w[0]), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid-rst stall", int'(st_w[0]), 0);
    chk("mid-rst bubble", int'(bb_w[0]), 0);
    chk("mid-rst fwd_a", int'(fa_w[0]), 0);
    chk("mid-rst stall_cnt", int'(sc_w[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic against the model, all three configurations
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(bit'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
